// File: rtl/axi_pkg.sv
// Shared AXI definitions for the framebuffer read responder.
package axi_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_t;

  localparam logic [2:0]  AXI_SIZE_32B   = 3'd5;
  localparam int unsigned AXI_BEAT_BYTES = 32;

endpackage

// File: rtl/fb_bram.sv
// Single-clock 256-bit block RAM: one read port, one write port, read-first.
module fb_bram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [255:0]     rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [255:0]     wr_data
);

  logic [255:0] mem_q [DEPTH];
  logic [255:0] rd_data_q;
  logic         wr_ok;

  assign wr_ok   = wr_en && (32'(wr_idx) < DEPTH);
  assign rd_data = rd_data_q;

  // The read register only loads on rd_en, so it doubles as the beat's
  // output holding register while the master stalls.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_q <= mem_q[rd_idx];
    end
    if (wr_ok) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/axi_fb_read_responder.sv
// AXI INCR read responder serving a framebuffer window out of fb_bram,
// with a side write port for filling the memory.
module axi_fb_read_responder
  import axi_pkg::*;
#(
  parameter logic [31:0]  fb_base     = 32'hBFE80000,
  parameter int unsigned  depth_words = 64,
  parameter int unsigned  max_arlen   = 15
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [31:0]                    ARADDR,
  input  logic [7:0]                     ARLEN,
  input  logic [2:0]                     ARSIZE,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [255:0]                   RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RLAST,
  output logic                           RVALID,
  input  logic                           RREADY,
  input  logic                           WR_EN,
  input  logic [$clog2(depth_words)-1:0] WR_IDX,
  input  logic [255:0]                   WR_DATA
);

  localparam int unsigned IDX_W      = $clog2(depth_words);
  localparam logic [32:0] WIN_START  = {1'b0, fb_base};
  localparam logic [32:0] WIN_END    = WIN_START + 33'(depth_words * AXI_BEAT_BYTES);
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFE0;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA
  } state_t;

  state_t       state_q, state_d;
  logic         arready_q, arready_d;
  logic [31:0]  addr_q, addr_d;
  logic [7:0]   len_q, len_d;
  logic [7:0]   cnt_q, cnt_d;
  resp_t        burst_resp_q, burst_resp_d;
  logic         rvalid_q, rvalid_d;
  logic         rlast_q, rlast_d;
  resp_t        rresp_q, rresp_d;
  logic         beat_ok_q, beat_ok_d;

  logic             in_window;
  resp_t            beat_resp;
  logic             ram_rd_en;
  logic [IDX_W-1:0] ram_idx;
  logic [255:0]     ram_rdata;

  assign in_window = ({1'b0, addr_q} >= WIN_START) && ({1'b0, addr_q} < WIN_END);
  assign ram_idx   = IDX_W'((addr_q - fb_base) >> 5);

  fb_bram #(
    .DEPTH (depth_words),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk     (ACLK),
    .rd_en   (ram_rd_en),
    .rd_idx  (ram_idx),
    .rd_data (ram_rdata),
    .wr_en   (WR_EN),
    .wr_idx  (WR_IDX),
    .wr_data (WR_DATA)
  );

  always_comb begin
    state_d      = state_q;
    arready_d    = arready_q;
    addr_d       = addr_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    burst_resp_d = burst_resp_q;
    rvalid_d     = rvalid_q;
    rlast_d      = rlast_q;
    rresp_d      = rresp_q;
    beat_ok_d    = beat_ok_q;
    ram_rd_en    = 1'b0;
    beat_resp    = in_window ? RESP_OKAY : RESP_DECERR;

    unique case (state_q)
      IDLE: begin
        arready_d = 1'b1;
        if (ARVALID && arready_q) begin
          addr_d       = ARADDR & ALIGN_MASK;
          len_d        = ARLEN;
          cnt_d        = '0;
          burst_resp_d = ((ARSIZE != AXI_SIZE_32B) || (32'(ARLEN) > max_arlen))
                         ? RESP_SLVERR : RESP_OKAY;
          arready_d    = 1'b0;
          state_d      = FETCH;
        end
      end

      FETCH: begin
        rresp_d   = (burst_resp_q != RESP_OKAY) ? burst_resp_q : beat_resp;
        beat_ok_d = (rresp_d == RESP_OKAY);
        ram_rd_en = beat_ok_d;
        rlast_d   = (cnt_q == len_q);
        rvalid_d  = 1'b1;
        state_d   = DATA;
      end

      DATA: begin
        if (RREADY) begin
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
          rresp_d   = RESP_OKAY;
          beat_ok_d = 1'b0;
          if (rlast_q) begin
            arready_d = 1'b1;
            state_d   = IDLE;
          end else begin
            addr_d  = addr_q + 32'(AXI_BEAT_BYTES);
            cnt_d   = cnt_q + 8'd1;
            state_d = FETCH;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= IDLE;
      arready_q    <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      burst_resp_q <= RESP_OKAY;
      rvalid_q     <= 1'b0;
      rlast_q      <= 1'b0;
      rresp_q      <= RESP_OKAY;
      beat_ok_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      arready_q    <= arready_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      burst_resp_q <= burst_resp_d;
      rvalid_q     <= rvalid_d;
      rlast_q      <= rlast_d;
      rresp_q      <= rresp_d;
      beat_ok_q    <= beat_ok_d;
    end
  end

  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RLAST   = rlast_q;
  assign RRESP   = rresp_q;
  assign RDATA   = beat_ok_q ? ram_rdata : '0;

endmodule

// File: tb/tb_axi_fb_read_responder.sv
// Self-checking bench for axi_fb_read_responder: directed table, corner sequences, random bursts.
module tb_axi_fb_read_responder;

  localparam logic [31:0] BASE   = 32'hBFE80000;
  localparam int          DEPTH  = 64;
  localparam int          MAXLEN = 15;

  logic         clk;
  logic         ARESET;
  logic [31:0]  ARADDR;
  logic [7:0]   ARLEN;
  logic [2:0]   ARSIZE;
  logic         ARVALID;
  logic         ARREADY;
  logic [255:0] RDATA;
  logic [1:0]   RRESP;
  logic         RLAST;
  logic         RVALID;
  logic         RREADY;
  logic         WR_EN;
  logic [5:0]   WR_IDX;
  logic [255:0] WR_DATA;

  axi_fb_read_responder #(
    .fb_base     (BASE),
    .depth_words (DEPTH),
    .max_arlen   (MAXLEN)
  ) dut (
    .ACLK    (clk),
    .ARESET  (ARESET),
    .ARADDR  (ARADDR),
    .ARLEN   (ARLEN),
    .ARSIZE  (ARSIZE),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RLAST   (RLAST),
    .RVALID  (RVALID),
    .RREADY  (RREADY),
    .WR_EN   (WR_EN),
    .WR_IDX  (WR_IDX),
    .WR_DATA (WR_DATA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] data;
    logic [1:0]   resp;
    logic         last;
  } beat_t;

  typedef struct {
    string       name;
    logic [31:0] addr;
    int          len;
    logic [2:0]  size;
    int          mode;
    logic [1:0]  first_resp;
    logic [1:0]  last_resp;
  } vec_t;

  int           checks = 0;
  int           errors = 0;
  logic [255:0] mem_m [DEPTH];
  beat_t        exp_q [$];
  vec_t         vt [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  // Reference: each beat address is the aligned start plus 32*i with 32-bit wrap.
  function automatic void model_burst(input logic [31:0] addr, input int len, input logic [2:0] size);
    beat_t       b;
    logic [31:0] a;
    logic [5:0]  wi;
    exp_q.delete();
    for (int i = 0; i <= len; i++) begin
      a = (addr & 32'hFFFF_FFE0) + 32'(i) * 32'd32;
      if (size != 3'd5 || len > MAXLEN)               b.resp = 2'd2;
      else if (a < BASE || a >= BASE + 32'(DEPTH*32)) b.resp = 2'd3;
      else                                            b.resp = 2'd0;
      wi     = 6'((a - BASE) >> 5);
      b.data = (b.resp == 2'd0) ? mem_m[wi] : '0;
      b.last = (i == len);
      exp_q.push_back(b);
    end
  endfunction

  task automatic side_write(input logic [5:0] idx, input logic [255:0] data);
    WR_EN   = 1'b1;
    WR_IDX  = idx;
    WR_DATA = data;
    tick();
    WR_EN   = 1'b0;
    mem_m[idx] = data;
  endtask

  task automatic start_ar(input string name, input logic [31:0] addr, input int len, input logic [2:0] size);
    for (int c = 0; c < 50 && !ARREADY; c++) tick();
    chk({name, " arready_wait"}, 256'(ARREADY), 256'(1));
    ARADDR  = addr;
    ARLEN   = 8'(len);
    ARSIZE  = size;
    ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    ARADDR  = $urandom;
    ARLEN   = 8'($urandom);
    ARSIZE  = 3'($urandom);
    chk({name, " arready_drop"}, 256'(ARREADY), 256'(0));
  endtask

  // Expected beats are checked on every valid cycle, so a stalled beat must
  // keep matching the same model entry until it is accepted.
  task automatic collect(input string name, input int mode,
                         output logic [1:0] first_r, output logic [1:0] last_r);
    int budget;
    int cyc;
    bit seen;
    bit got_first;
    bit tog;
    budget    = 8 * exp_q.size() + 20;
    cyc       = 1;
    seen      = 0;
    got_first = 0;
    tog       = 0;
    first_r   = 2'd1;
    last_r    = 2'd1;
    while (exp_q.size() > 0 && cyc < budget) begin
      case (mode)
        0:       RREADY = 1'b1;
        1:       begin RREADY = tog; tog = ~tog; end
        default: RREADY = 1'($urandom_range(0, 1));
      endcase
      if (RVALID) begin
        if (!seen) begin
          seen = 1;
          chk({name, " latency"}, 256'(cyc), 256'(2));
        end
        chk({name, " rdata"}, RDATA, exp_q[0].data);
        chk({name, " rresp"}, 256'(RRESP), 256'(exp_q[0].resp));
        chk({name, " rlast"}, 256'(RLAST), 256'(exp_q[0].last));
        if (RREADY) begin
          if (!got_first) begin
            got_first = 1;
            first_r   = RRESP;
          end
          last_r = RRESP;
          void'(exp_q.pop_front());
        end
      end
      tick();
      cyc++;
    end
    RREADY = 1'b0;
    chk({name, " beats_left"}, 256'(exp_q.size()), 256'(0));
    exp_q.delete();
    chk({name, " rvalid_after"}, 256'(RVALID), 256'(0));
    chk({name, " arready_after"}, 256'(ARREADY), 256'(1));
  endtask

  task automatic run_burst(input string name, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input int mode,
                           output logic [1:0] first_r, output logic [1:0] last_r);
    model_burst(addr, len, size);
    start_ar(name, addr, len, size);
    collect(name, mode, first_r, last_r);
  endtask

  initial begin
    logic [1:0]  fr;
    logic [1:0]  lr;
    logic [31:0] ra;
    int          rl;
    logic [2:0]  rs;
    int          nb;

    ARESET  = 1'b1;
    ARADDR  = '0;
    ARLEN   = '0;
    ARSIZE  = '0;
    ARVALID = 1'b0;
    RREADY  = 1'b0;
    WR_EN   = 1'b0;
    WR_IDX  = '0;
    WR_DATA = '0;

    vt[0]  = '{"basic",      BASE,                 3,  3'd5, 0, 2'd0, 2'd0};
    vt[1]  = '{"toggle",     BASE,                 3,  3'd5, 1, 2'd0, 2'd0};
    vt[2]  = '{"run_off",    BASE + 32'(62*32),    3,  3'd5, 2, 2'd0, 2'd3};
    vt[3]  = '{"size4",      BASE,                 1,  3'd4, 0, 2'd2, 2'd2};
    vt[4]  = '{"len16",      BASE,                 16, 3'd5, 1, 2'd2, 2'd2};
    vt[5]  = '{"below_base", BASE - 32'd32,        1,  3'd5, 0, 2'd3, 2'd0};
    vt[6]  = '{"wrap",       32'hFFFF_FFE0,        1,  3'd5, 0, 2'd3, 2'd3};
    vt[7]  = '{"unaligned",  BASE + 32'd5,         0,  3'd5, 2, 2'd0, 2'd0};
    vt[8]  = '{"last_word",  BASE + 32'(63*32),    0,  3'd5, 0, 2'd0, 2'd0};
    vt[9]  = '{"past_end",   BASE + 32'(64*32),    0,  3'd5, 1, 2'd3, 2'd3};
    vt[10] = '{"len15",      BASE + 32'(10*32),    15, 3'd5, 2, 2'd0, 2'd0};

    // Preload while held in reset: side writes must still land.
    for (int i = 0; i < DEPTH; i++) begin
      side_write(6'(i), (i < 4) ? 256'(i + 1) : {$urandom, $urandom, $urandom, $urandom,
                                                 $urandom, $urandom, $urandom, $urandom});
    end
    chk("rst arready", 256'(ARREADY), 256'(0));
    chk("rst rvalid",  256'(RVALID),  256'(0));
    chk("rst rlast",   256'(RLAST),   256'(0));
    chk("rst rresp",   256'(RRESP),   256'(0));
    chk("rst rdata",   RDATA,         256'(0));
    ARESET = 1'b0;
    tick();

    for (int v = 0; v < 11; v++) begin
      run_burst(vt[v].name, vt[v].addr, vt[v].len, vt[v].size, vt[v].mode, fr, lr);
      chk({vt[v].name, " first_resp"}, 256'(fr), 256'(vt[v].first_resp));
      chk({vt[v].name, " last_resp"},  256'(lr), 256'(vt[v].last_resp));
    end

    // Read-first: overwrite idx 5 in the very cycle FETCH reads it.
    side_write(6'd5, 256'hAA);
    model_burst(BASE + 32'(5*32), 0, 3'd5);
    start_ar("rdfirst", BASE + 32'(5*32), 0, 3'd5);
    WR_EN   = 1'b1;
    WR_IDX  = 6'd5;
    WR_DATA = 256'hBB;
    collect("rdfirst", 0, fr, lr);
    WR_EN = 1'b0;
    mem_m[5] = 256'hBB;
    chk("rdfirst model_old", mem_m[5], 256'hBB);
    run_burst("rdfirst_new", BASE + 32'(5*32), 0, 3'd5, 0, fr, lr);

    // Reset during beat 2 of a 4-beat burst.
    side_write(6'd0, 256'h1);
    side_write(6'd1, 256'h2);
    side_write(6'd2, 256'h3);
    side_write(6'd3, 256'h4);
    start_ar("midrst", BASE, 3, 3'd5);
    RREADY = 1'b1;
    nb = 0;
    for (int c = 0; c < 20 && nb < 2; c++) begin
      if (RVALID) nb++;
      if (nb < 2) tick();
    end
    chk("midrst reach_beat2", 256'(nb), 256'(2));
    ARESET = 1'b1;
    tick();
    chk("midrst rvalid",  256'(RVALID),  256'(0));
    chk("midrst arready", 256'(ARREADY), 256'(0));
    chk("midrst rlast",   256'(RLAST),   256'(0));
    chk("midrst rdata",   RDATA,         256'(0));
    ARESET = 1'b0;
    nb = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (RVALID) nb++;
    end
    chk("midrst stray_beats", 256'(nb), 256'(0));
    chk("midrst arready_back", 256'(ARREADY), 256'(1));
    RREADY = 1'b0;
    run_burst("post_rst", BASE, 3, 3'd5, 2, fr, lr);

    // Randomized bursts interleaved with side writes.
    for (int r = 0; r < 40; r++) begin
      for (int w = 0; w < int'($urandom_range(0, 2)); w++) begin
        side_write(6'($urandom), {$urandom, $urandom, $urandom, $urandom,
                                  $urandom, $urandom, $urandom, $urandom});
      end
      case ($urandom_range(0, 3))
        0:       ra = BASE + 32'($urandom_range(0, 63) * 32) + 32'($urandom_range(0, 31));
        1:       ra = BASE + 32'($urandom_range(56, 70) * 32);
        2:       ra = BASE - 32'($urandom_range(1, 3) * 32);
        default: ra = $urandom;
      endcase
      rl = $urandom_range(0, 18);
      rs = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'd5;
      run_burst("rand", ra, rl, rs, $urandom_range(0, 2), fr, lr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
